// File: rtl/if_fetch_unit_if.sv
// Purpose: IF/ID handshake bundle between the fetch unit and the decode stage.
//   o_if_valid  fetch -> decode  slot holds a live instruction
//   o_if_pc     fetch -> decode  byte address of o_if_instr
//   o_if_instr  fetch -> decode  fetched instruction word
//   i_id_ready  decode -> fetch  decode accepts the slot this cycle
interface if_fetch_unit_if;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        i_id_ready;

  modport master (
    output o_if_valid,
    output o_if_pc,
    output o_if_instr,
    input  i_id_ready
  );

  modport slave (
    input  o_if_valid,
    input  o_if_pc,
    input  o_if_instr,
    output i_id_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Purpose: instruction-fetch front end. Owns the PC, addresses a combinational
// instruction memory and captures the returned word into the IF/ID register.
// Supports redirect with squash, stall hold and a fault halt on misaligned or
// out-of-range fetch addresses.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   o_imem_addr       byte address to imem (the pc register itself)
//   i_imem_data       instruction word for o_imem_addr
//   i_stall           hold pc and IF/ID register
//   i_redirect_valid  redirect pc to i_redirect_pc, squashing the slot
//   i_redirect_pc     redirect target
//   id_bus            IF/ID valid/ready handshake (master side)
//   o_fault           fetch fault latched, unit halted
//   o_fault_pc        address that caused the latched fault
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 2048,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [31:0]             o_imem_addr,
  input  logic [31:0]             i_imem_data,
  input  logic                    i_stall,
  input  logic                    i_redirect_valid,
  input  logic [31:0]             i_redirect_pc,
  if_fetch_unit_if.master         id_bus,
  output logic                    o_fault,
  output logic [31:0]             o_fault_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [30:0] WORD_LIMIT = 31'(IMEM_WORDS);

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        valid_r, valid_s;
  logic [31:0] if_pc_r, if_pc_s;
  logic [31:0] instr_r, instr_s;
  logic        fault_r, fault_s;
  logic [31:0] fault_pc_r, fault_pc_s;
  logic        pc_illegal_s;
  logic        hold_s;

  // Fetch legality: word aligned and inside the memory depth.
  assign pc_illegal_s = (pc_r[1:0] != 2'b00) || ({1'b0, pc_r[31:2]} >= WORD_LIMIT);
  // Hold when stalled or when decode has not taken a pending slot.
  assign hold_s = i_stall || (valid_r && !id_bus.i_id_ready);

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    valid_s    = valid_r;
    if_pc_s    = if_pc_r;
    instr_s    = instr_r;
    fault_s    = fault_r;
    fault_pc_s = fault_pc_r;
    case (state_r)
      BOOT: begin
        // Settle cycle for imem; a redirect still lands in pc.
        state_s = RUN;
        if (i_redirect_valid) begin
          pc_s = i_redirect_pc;
        end else begin
          pc_s = pc_r;
        end
      end
      RUN: begin
        if (i_redirect_valid) begin
          // Squash wins over stall and backpressure.
          pc_s    = i_redirect_pc;
          valid_s = 1'b0;
          instr_s = NOP_INSTR;
        end else if (hold_s) begin
          pc_s    = pc_r;
          valid_s = valid_r;
        end else if (pc_illegal_s) begin
          // Reached only once any pending slot has been accepted.
          fault_s    = 1'b1;
          fault_pc_s = pc_r;
          valid_s    = 1'b0;
          state_s    = HALT;
        end else begin
          if_pc_s = pc_r;
          instr_s = i_imem_data;
          valid_s = 1'b1;
          pc_s    = pc_r + 32'd4;
        end
      end
      HALT: begin
        if (i_redirect_valid) begin
          fault_s = 1'b0;
          pc_s    = i_redirect_pc;
          valid_s = 1'b0;
          state_s = RUN;
        end else begin
          valid_s = 1'b0;
        end
      end
      default: begin
        state_s = BOOT;
        valid_s = 1'b0;
        instr_s = NOP_INSTR;
      end
    endcase
  end

  // State and pipeline register update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      valid_r    <= 1'b0;
      if_pc_r    <= 32'h0000_0000;
      instr_r    <= NOP_INSTR;
      fault_r    <= 1'b0;
      fault_pc_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      valid_r    <= valid_s;
      if_pc_r    <= if_pc_s;
      instr_r    <= instr_s;
      fault_r    <= fault_s;
      fault_pc_r <= fault_pc_s;
    end
  end

  assign o_imem_addr       = pc_r;
  assign id_bus.o_if_valid = valid_r;
  assign id_bus.o_if_pc    = if_pc_r;
  assign id_bus.o_if_instr = instr_r;
  assign o_fault           = fault_r;
  assign o_fault_pc        = fault_pc_r;

endmodule
